axi_slave_ram: RTL and testbench

- AXI4-full slave (responder) backed by an internal dual-port word RAM.
- Sits at the far end of the team's AXI master FIFO interface. It is the bench/co-simulation memory target, and doubles as an on-chip scratch RAM.
- Serves INCR bursts of up to 256 beats of 32-bit data, single outstanding read and single outstanding write; the read and write paths are fully independent.

---
 rtl/axi_slave_ram_if.sv | 59 +++++
 rtl/axi_slave_ram.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axi_slave_ram.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_ram_if.sv
// AXI4 read/write channel bundle between a master and axi_slave_ram.
// The slave modport is the RAM side; the master modport is the requester side.
interface axi_slave_ram_if;
    logic        AXI_S_ARID;
    logic [31:0] AXI_S_ARADDR;
    logic [7:0]  AXI_S_ARLEN;
    logic [2:0]  AXI_S_ARSIZE;
    logic [1:0]  AXI_S_ARBURST;
    logic [3:0]  AXI_S_ARCACHE;
    logic [2:0]  AXI_S_ARPROT;
    logic        AXI_S_ARVALID;
    logic        AXI_S_ARREADY;
    logic        AXI_S_RID;
    logic [31:0] AXI_S_RDATA;
    logic [1:0]  AXI_S_RRESP;
    logic        AXI_S_RLAST;
    logic        AXI_S_RVALID;
    logic        AXI_S_RREADY;
    logic        AXI_S_AWID;
    logic [31:0] AXI_S_AWADDR;
    logic [7:0]  AXI_S_AWLEN;
    logic [2:0]  AXI_S_AWSIZE;
    logic [1:0]  AXI_S_AWBURST;
    logic [3:0]  AXI_S_AWCACHE;
    logic [2:0]  AXI_S_AWPROT;
    logic        AXI_S_AWVALID;
    logic        AXI_S_AWREADY;
    logic [31:0] AXI_S_WDATA;
    logic [3:0]  AXI_S_WSTRB;
    logic        AXI_S_WLAST;
    logic        AXI_S_WVALID;
    logic        AXI_S_WREADY;
    logic        AXI_S_BID;
    logic [1:0]  AXI_S_BRESP;
    logic        AXI_S_BVALID;
    logic        AXI_S_BREADY;

    modport slave (
        input  AXI_S_ARID, AXI_S_ARADDR, AXI_S_ARLEN, AXI_S_ARSIZE, AXI_S_ARBURST,
               AXI_S_ARCACHE, AXI_S_ARPROT, AXI_S_ARVALID, AXI_S_RREADY,
               AXI_S_AWID, AXI_S_AWADDR, AXI_S_AWLEN, AXI_S_AWSIZE, AXI_S_AWBURST,
               AXI_S_AWCACHE, AXI_S_AWPROT, AXI_S_AWVALID,
               AXI_S_WDATA, AXI_S_WSTRB, AXI_S_WLAST, AXI_S_WVALID, AXI_S_BREADY,
        output AXI_S_ARREADY, AXI_S_RID, AXI_S_RDATA, AXI_S_RRESP, AXI_S_RLAST,
               AXI_S_RVALID, AXI_S_AWREADY, AXI_S_WREADY, AXI_S_BID, AXI_S_BRESP,
               AXI_S_BVALID
    );

    modport master (
        output AXI_S_ARID, AXI_S_ARADDR, AXI_S_ARLEN, AXI_S_ARSIZE, AXI_S_ARBURST,
               AXI_S_ARCACHE, AXI_S_ARPROT, AXI_S_ARVALID, AXI_S_RREADY,
               AXI_S_AWID, AXI_S_AWADDR, AXI_S_AWLEN, AXI_S_AWSIZE, AXI_S_AWBURST,
               AXI_S_AWCACHE, AXI_S_AWPROT, AXI_S_AWVALID,
               AXI_S_WDATA, AXI_S_WSTRB, AXI_S_WLAST, AXI_S_WVALID, AXI_S_BREADY,
        input  AXI_S_ARREADY, AXI_S_RID, AXI_S_RDATA, AXI_S_RRESP, AXI_S_RLAST,
               AXI_S_RVALID, AXI_S_AWREADY, AXI_S_WREADY, AXI_S_BID, AXI_S_BRESP,
               AXI_S_BVALID
    );
endinterface

// File: rtl/axi_slave_ram.sv
// AXI4 INCR-burst slave over a word RAM, independent single-outstanding read and write paths.
// Optional random back-pressure when AXI_SLAVE_RAM_STALL_EN is defined.
module axi_slave_ram #(
    parameter int ADDR_BITS = 12,
    parameter int INIT_ZERO = 1
) (
    input  logic           ACLK,
    input  logic           ARESETN,
    axi_slave_ram_if.slave axi_s
);
    localparam int         IDX_W       = ADDR_BITS - 2;
    localparam int         RAM_WORDS   = 1 << IDX_W;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic       {R_IDLE, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    function automatic logic burst_legal(input logic [2:0] size, input logic [1:0] burst);
        return (size == 3'd2) && (burst == 2'b01);
    endfunction

    logic [31:0] mem_q [RAM_WORDS] = '{default: ((INIT_ZERO != 0) ? 32'h0 : 32'hx)};

    r_state_e         r_state_q, r_state_d;
    logic             arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic             rid_q, rid_d, r_legal_q, r_legal_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [IDX_W-1:0] r_idx_q, r_idx_d, launch_idx_s;
    logic [7:0]       r_cnt_q, r_cnt_d, launch_cnt_s;
    logic             launch_s, launch_legal_s;

    w_state_e         w_state_q, w_state_d;
    logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic             bid_q, bid_d, w_legal_q, w_legal_d, w_err_q, w_err_d, last_err_s;
    logic [1:0]       bresp_q, bresp_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic [7:0]       w_cnt_q, w_cnt_d;
    logic             mem_we_s, stall_nx_s, unused_s;

`ifdef AXI_SLAVE_RAM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1; its next value decides the stall of the coming cycle
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end

    assign stall_nx_s = lfsr_d[0];
`else
    assign stall_nx_s = 1'b0;
`endif

    // Read path next state; a beat is "launched" by sampling the RAM into the R output registers
    always_comb begin
        r_state_d      = r_state_q;
        arready_d      = 1'b0;
        rvalid_d       = rvalid_q;
        rdata_d        = rdata_q;
        rresp_d        = rresp_q;
        rlast_d        = rlast_q;
        rid_d          = rid_q;
        r_idx_d        = r_idx_q;
        r_cnt_d        = r_cnt_q;
        r_legal_d      = r_legal_q;
        launch_s       = 1'b0;
        launch_idx_s   = r_idx_q;
        launch_cnt_s   = r_cnt_q;
        launch_legal_s = r_legal_q;
        case (r_state_q)
            R_IDLE: begin
                if (arready_q && axi_s.AXI_S_ARVALID) begin
                    r_state_d      = R_BURST;
                    rid_d          = axi_s.AXI_S_ARID;
                    r_legal_d      = burst_legal(axi_s.AXI_S_ARSIZE, axi_s.AXI_S_ARBURST);
                    r_idx_d        = axi_s.AXI_S_ARADDR[ADDR_BITS-1:2];
                    r_cnt_d        = axi_s.AXI_S_ARLEN;
                    launch_idx_s   = axi_s.AXI_S_ARADDR[ADDR_BITS-1:2];
                    launch_cnt_s   = axi_s.AXI_S_ARLEN;
                    launch_legal_s = burst_legal(axi_s.AXI_S_ARSIZE, axi_s.AXI_S_ARBURST);
                    launch_s       = ~stall_nx_s;
                end else begin
                    arready_d = ~stall_nx_s;
                end
            end
            R_BURST: begin
                if (rvalid_q) begin
                    if (axi_s.AXI_S_RREADY) begin
                        rvalid_d = 1'b0;
                        if (rlast_q) begin
                            r_state_d = R_IDLE;
                            arready_d = ~stall_nx_s;
                        end else begin
                            launch_s = ~stall_nx_s;
                        end
                    end else begin
                        rvalid_d = 1'b1;
                    end
                end else begin
                    launch_s = ~stall_nx_s;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (launch_s) begin
            rvalid_d = 1'b1;
            rdata_d  = launch_legal_s ? mem_q[launch_idx_s] : 32'h0;
            rresp_d  = launch_legal_s ? RESP_OKAY : RESP_SLVERR;
            rlast_d  = (launch_cnt_s == 8'd0);
            r_idx_d  = launch_idx_s + 1'b1;
            r_cnt_d  = launch_cnt_s - 8'd1;
        end else begin
            rlast_d = rlast_q;
        end
    end

    // Read path registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
            rid_q     <= 1'b0;
            r_idx_q   <= '0;
            r_cnt_q   <= 8'd0;
            r_legal_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            r_legal_q <= r_legal_d;
        end
    end

    // WLAST disagreeing with the LEN-derived final beat is flagged but never changes the beat count
    assign last_err_s = w_err_q | (axi_s.AXI_S_WLAST != (w_cnt_q == 8'd0));

    // Write path next state
    always_comb begin
        w_state_d = w_state_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        w_legal_d = w_legal_q;
        w_err_d   = w_err_q;
        mem_we_s  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awready_q && axi_s.AXI_S_AWVALID) begin
                    w_state_d = W_DATA;
                    bid_d     = axi_s.AXI_S_AWID;
                    w_idx_d   = axi_s.AXI_S_AWADDR[ADDR_BITS-1:2];
                    w_cnt_d   = axi_s.AXI_S_AWLEN;
                    w_legal_d = burst_legal(axi_s.AXI_S_AWSIZE, axi_s.AXI_S_AWBURST);
                    w_err_d   = ~burst_legal(axi_s.AXI_S_AWSIZE, axi_s.AXI_S_AWBURST);
                    wready_d  = ~stall_nx_s;
                end else begin
                    awready_d = ~stall_nx_s;
                end
            end
            W_DATA: begin
                if (wready_q && axi_s.AXI_S_WVALID) begin
                    mem_we_s = w_legal_q;
                    w_idx_d  = w_idx_q + 1'b1;
                    w_cnt_d  = w_cnt_q - 8'd1;
                    w_err_d  = last_err_s;
                    if (w_cnt_q == 8'd0) begin
                        w_state_d = W_RESP;
                        bresp_d   = last_err_s ? RESP_SLVERR : RESP_OKAY;
                        bvalid_d  = ~stall_nx_s;
                    end else begin
                        wready_d = ~stall_nx_s;
                    end
                end else begin
                    wready_d = ~stall_nx_s;
                end
            end
            W_RESP: begin
                if (bvalid_q) begin
                    if (axi_s.AXI_S_BREADY) begin
                        bvalid_d  = 1'b0;
                        w_state_d = W_IDLE;
                        awready_d = ~stall_nx_s;
                    end else begin
                        bvalid_d = 1'b1;
                    end
                end else begin
                    bvalid_d = ~stall_nx_s;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write path registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= 1'b0;
            w_idx_q   <= '0;
            w_cnt_q   <= 8'd0;
            w_legal_q <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            w_legal_q <= w_legal_d;
            w_err_q   <= w_err_d;
        end
    end

    // RAM write port; contents survive reset, and the read port samples old data on a same-word collision
    always_ff @(posedge ACLK) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (axi_s.AXI_S_WSTRB[i]) mem_q[w_idx_q][8*i +: 8] <= axi_s.AXI_S_WDATA[8*i +: 8];
            end
        end
    end

    assign axi_s.AXI_S_ARREADY = arready_q;
    assign axi_s.AXI_S_RVALID  = rvalid_q;
    assign axi_s.AXI_S_RDATA   = rdata_q;
    assign axi_s.AXI_S_RRESP   = rresp_q;
    assign axi_s.AXI_S_RLAST   = rlast_q;
    assign axi_s.AXI_S_RID     = rid_q;
    assign axi_s.AXI_S_AWREADY = awready_q;
    assign axi_s.AXI_S_WREADY  = wready_q;
    assign axi_s.AXI_S_BVALID  = bvalid_q;
    assign axi_s.AXI_S_BRESP   = bresp_q;
    assign axi_s.AXI_S_BID     = bid_q;

    assign unused_s = ^{axi_s.AXI_S_ARCACHE, axi_s.AXI_S_ARPROT, axi_s.AXI_S_AWCACHE,
                        axi_s.AXI_S_AWPROT, axi_s.AXI_S_ARADDR[31:ADDR_BITS],
                        axi_s.AXI_S_ARADDR[1:0], axi_s.AXI_S_AWADDR[31:ADDR_BITS],
                        axi_s.AXI_S_AWADDR[1:0]};
endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed self-checking bench for axi_slave_ram (default build, no stall logic).
// Expected values are hand-computed from the burst contents written by the bench.
module tb_axi_slave_ram;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;
    logic [31:0] wdat [256];
    logic [31:0] rexp [256];

    axi_slave_ram_if bus ();

    axi_slave_ram #(.ADDR_BITS(12), .INIT_ZERO(1)) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .axi_s   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [3:0] strb, input int wlast_at, input logic id,
                             input logic [1:0] exp_resp);
        int n;
        check_val("wready_idle", 32'(bus.AXI_S_WREADY), 32'd0);
        bus.AXI_S_AWID    = id;
        bus.AXI_S_AWADDR  = addr;
        bus.AXI_S_AWLEN   = 8'(len);
        bus.AXI_S_AWSIZE  = size;
        bus.AXI_S_AWBURST = 2'b01;
        bus.AXI_S_AWVALID = 1'b1;
        n = 0;
        while (!bus.AXI_S_AWREADY && n < TMO) begin tick(); n++; end
        check_val("awready", 32'(bus.AXI_S_AWREADY), 32'd1);
        tick();
        bus.AXI_S_AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.AXI_S_WDATA  = wdat[i];
            bus.AXI_S_WSTRB  = strb;
            bus.AXI_S_WLAST  = (i == wlast_at);
            bus.AXI_S_WVALID = 1'b1;
            n = 0;
            while (!bus.AXI_S_WREADY && n < TMO) begin tick(); n++; end
            if (!bus.AXI_S_WREADY) begin
                check_val("wready", 32'd0, 32'd1);
                break;
            end
            tick();
        end
        bus.AXI_S_WVALID = 1'b0;
        bus.AXI_S_WLAST  = 1'b0;
        check_val("wready_after", 32'(bus.AXI_S_WREADY), 32'd0);
        bus.AXI_S_BREADY = 1'b1;
        n = 0;
        while (!bus.AXI_S_BVALID && n < TMO) begin tick(); n++; end
        check_val("bvalid", 32'(bus.AXI_S_BVALID), 32'd1);
        check_val("bresp", 32'(bus.AXI_S_BRESP), 32'(exp_resp));
        check_val("bid", 32'(bus.AXI_S_BID), 32'(id));
        tick();
        bus.AXI_S_BREADY = 1'b0;
        check_val("bvalid_drop", 32'(bus.AXI_S_BVALID), 32'd0);
        check_val("awready_back", 32'(bus.AXI_S_AWREADY), 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic id, input logic [1:0] exp_resp, input bit toggle);
        int  n;
        int  beat;
        logic rr;
        bus.AXI_S_ARID    = id;
        bus.AXI_S_ARADDR  = addr;
        bus.AXI_S_ARLEN   = 8'(len);
        bus.AXI_S_ARSIZE  = size;
        bus.AXI_S_ARBURST = 2'b01;
        bus.AXI_S_ARVALID = 1'b1;
        n = 0;
        while (!bus.AXI_S_ARREADY && n < TMO) begin tick(); n++; end
        check_val("arready", 32'(bus.AXI_S_ARREADY), 32'd1);
        tick();
        bus.AXI_S_ARVALID = 1'b0;
        check_val("rvalid_lat", 32'(bus.AXI_S_RVALID), 32'd1);
        check_val("arready_busy", 32'(bus.AXI_S_ARREADY), 32'd0);
        beat = 0;
        n = 0;
        rr = 1'b1;
        while (beat <= len && n < 4 * TMO + 2 * len) begin
            bus.AXI_S_RREADY = toggle ? rr : 1'b1;
            if (bus.AXI_S_RVALID) begin
                check_val("rdata", bus.AXI_S_RDATA, (exp_resp == 2'b00) ? rexp[beat] : 32'h0);
                check_val("rresp", 32'(bus.AXI_S_RRESP), 32'(exp_resp));
                check_val("rlast", 32'(bus.AXI_S_RLAST), 32'(beat == len));
                check_val("rid", 32'(bus.AXI_S_RID), 32'(id));
                if (bus.AXI_S_RREADY) beat++;
            end
            rr = ~rr;
            tick();
            n++;
        end
        bus.AXI_S_RREADY = 1'b0;
        check_val("rbeats", 32'(beat), 32'(len + 1));
        if (!toggle) check_val("rcycles", 32'(n), 32'(len + 1));
        check_val("rvalid_end", 32'(bus.AXI_S_RVALID), 32'd0);
        check_val("arready_back", 32'(bus.AXI_S_ARREADY), 32'd1);
    endtask

    initial begin
        bus.AXI_S_ARID = 1'b0;    bus.AXI_S_ARADDR = 32'h0;  bus.AXI_S_ARLEN = 8'd0;
        bus.AXI_S_ARSIZE = 3'd2;  bus.AXI_S_ARBURST = 2'b01; bus.AXI_S_ARCACHE = 4'h0;
        bus.AXI_S_ARPROT = 3'd0;  bus.AXI_S_ARVALID = 1'b0;  bus.AXI_S_RREADY = 1'b0;
        bus.AXI_S_AWID = 1'b0;    bus.AXI_S_AWADDR = 32'h0;  bus.AXI_S_AWLEN = 8'd0;
        bus.AXI_S_AWSIZE = 3'd2;  bus.AXI_S_AWBURST = 2'b01; bus.AXI_S_AWCACHE = 4'h0;
        bus.AXI_S_AWPROT = 3'd0;  bus.AXI_S_AWVALID = 1'b0;  bus.AXI_S_WDATA = 32'h0;
        bus.AXI_S_WSTRB = 4'h0;   bus.AXI_S_WLAST = 1'b0;    bus.AXI_S_WVALID = 1'b0;
        bus.AXI_S_BREADY = 1'b0;

        // Reset state and release
        repeat (3) tick();
        check_val("rst_arready", 32'(bus.AXI_S_ARREADY), 32'd0);
        check_val("rst_awready", 32'(bus.AXI_S_AWREADY), 32'd0);
        check_val("rst_rvalid", 32'(bus.AXI_S_RVALID), 32'd0);
        check_val("rst_bvalid", 32'(bus.AXI_S_BVALID), 32'd0);
        rst_n = 1'b1;
        check_val("rel_arready", 32'(bus.AXI_S_ARREADY), 32'd0);
        tick();
        check_val("rel_arready1", 32'(bus.AXI_S_ARREADY), 32'd1);
        check_val("rel_awready1", 32'(bus.AXI_S_AWREADY), 32'd1);

        // 256-beat write of the index, read back with RREADY toggling
        for (int i = 0; i < 256; i++) begin wdat[i] = 32'(i); rexp[i] = 32'(i); end
        axi_write(32'h000, 255, 3'd2, 4'hF, 255, 1'b0, 2'b00);
        axi_read(32'h000, 255, 3'd2, 1'b1, 2'b00, 1'b1);

        // Basic 4-beat burst at 0x100
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
        rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
        axi_write(32'h100, 3, 3'd2, 4'hF, 3, 1'b1, 2'b00);
        axi_read(32'h100, 3, 3'd2, 1'b1, 2'b00, 1'b0);

        // Byte strobes: 0xAABBCCDD with WSTRB=0101 over 0xFFFFFFFF
        wdat[0] = 32'hFFFF_FFFF;
        axi_write(32'h200, 0, 3'd2, 4'hF, 0, 1'b0, 2'b00);
        wdat[0] = 32'hAABB_CCDD;
        axi_write(32'h200, 0, 3'd2, 4'b0101, 0, 1'b1, 2'b00);
        rexp[0] = 32'hFFBB_FFDD;
        axi_read(32'h200, 0, 3'd2, 1'b0, 2'b00, 1'b0);

        // Address wrap at the top of the 4 KiB window
        wdat[0] = 32'hCAFE_0001; wdat[1] = 32'hCAFE_0002;
        axi_write(32'hFFC, 1, 3'd2, 4'hF, 1, 1'b0, 2'b00);
        rexp[0] = 32'hCAFE_0001; rexp[1] = 32'hCAFE_0002;
        axi_read(32'hFFC, 1, 3'd2, 1'b1, 2'b00, 1'b0);
        rexp[0] = 32'hCAFE_0002;
        axi_read(32'h000, 0, 3'd2, 1'b0, 2'b00, 1'b0);

        // Illegal size read and write; the write must leave RAM untouched
        axi_read(32'h100, 1, 3'd1, 1'b1, 2'b10, 1'b0);
        wdat[0] = 32'hDEAD_BEEF;
        axi_write(32'h100, 0, 3'd1, 4'hF, 0, 1'b1, 2'b10);
        rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
        axi_read(32'h100, 3, 3'd2, 1'b0, 2'b00, 1'b0);

        // WLAST early on beat 2 of 3, then WLAST missing: data written, SLVERR reported
        wdat[0] = 32'hA0A0_0001; wdat[1] = 32'hA0A0_0002; wdat[2] = 32'hA0A0_0003;
        axi_write(32'h300, 2, 3'd2, 4'hF, 1, 1'b1, 2'b10);
        rexp[0] = 32'hA0A0_0001; rexp[1] = 32'hA0A0_0002; rexp[2] = 32'hA0A0_0003;
        axi_read(32'h300, 2, 3'd2, 1'b1, 2'b00, 1'b0);
        wdat[0] = 32'h5555_0001; wdat[1] = 32'h5555_0002;
        axi_write(32'h310, 1, 3'd2, 4'hF, -1, 1'b0, 2'b10);
        rexp[0] = 32'h5555_0001; rexp[1] = 32'h5555_0002;
        axi_read(32'h310, 1, 3'd2, 1'b0, 2'b00, 1'b0);

        // Reset in the middle of a 16-beat read
        bus.AXI_S_ARID = 1'b1; bus.AXI_S_ARADDR = 32'h000; bus.AXI_S_ARLEN = 8'd15;
        bus.AXI_S_ARSIZE = 3'd2; bus.AXI_S_ARVALID = 1'b1;
        check_val("mid_arready", 32'(bus.AXI_S_ARREADY), 32'd1);
        tick();
        bus.AXI_S_ARVALID = 1'b0;
        bus.AXI_S_RREADY  = 1'b1;
        repeat (3) tick();
        check_val("mid_rvalid", 32'(bus.AXI_S_RVALID), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_rvalid", 32'(bus.AXI_S_RVALID), 32'd0);
        check_val("mid_rst_rlast", 32'(bus.AXI_S_RLAST), 32'd0);
        check_val("mid_rst_arready", 32'(bus.AXI_S_ARREADY), 32'd0);
        check_val("mid_rst_awready", 32'(bus.AXI_S_AWREADY), 32'd0);
        check_val("mid_rst_wready", 32'(bus.AXI_S_WREADY), 32'd0);
        check_val("mid_rst_bvalid", 32'(bus.AXI_S_BVALID), 32'd0);
        bus.AXI_S_RREADY = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check_val("mid_rel_arready0", 32'(bus.AXI_S_ARREADY), 32'd0);
        tick();
        check_val("mid_rel_arready1", 32'(bus.AXI_S_ARREADY), 32'd1);
        check_val("mid_rel_rvalid", 32'(bus.AXI_S_RVALID), 32'd0);
        rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
        axi_read(32'h100, 3, 3'd2, 1'b1, 2'b00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
